// File: rtl/falling_char_pool.sv
// Pool of falling characters: spawns, advances per frame, retires on hit/miss; slot read port for the renderer.
// Optional KEY_CASE_FOLD_EN folds lowercase keys to uppercase before capture.
module falling_char_pool #(
  parameter int         SLOTS  = 4,
  parameter logic [8:0] BOTTOM = 9'd464,
  parameter int         CNT_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             spawn_tick,
  input  logic [7:0]       gen_ch,
  input  logic [2:0]       gen_speed,
  input  logic [8:0]       gen_x,
  input  logic [9:0]       gen_y,
  input  logic             key_valid,
  input  logic [7:0]       key_ch,
  input  logic [2:0]       rd_idx,
  output logic             rd_valid,
  output logic [7:0]       rd_ch,
  output logic [8:0]       rd_x,
  output logic [9:0]       rd_y,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             hit_pulse,
  output logic             miss_pulse,
  output logic             mistype_pulse,
  output logic             busy
);

  typedef struct packed {
    logic       vld;
    logic [7:0] ch;
    logic [2:0] spd;
    logic [8:0] x;
    logic [9:0] y;
  } slot_t;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_KEY, S_SPAWN} state_t;

  state_t           r_state;
  slot_t            r_slot [SLOTS];
  logic [2:0]       r_mv_idx;
  logic             r_frame_pend;
  logic             r_key_pend;
  logic             r_spawn_pend;
  logic [7:0]       r_key_ch;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;
  logic             r_hit_pulse;
  logic             r_miss_pulse;
  logic             r_mistype_pulse;

  logic [7:0] w_key_in;
  slot_t      w_mv_slot;
  logic [9:0] w_nx;
  logic       w_miss;
  logic       w_hit_found;
  logic [2:0] w_hit_idx;
  logic [8:0] w_best_x;
  logic       w_free_found;
  logic [2:0] w_free_idx;
  logic       w_frame_take;
  logic       w_key_take;
  logic       w_spawn_take;

`ifdef KEY_CASE_FOLD_EN
  assign w_key_in = (key_ch >= 8'd97 && key_ch <= 8'd122) ? key_ch - 8'd32 : key_ch;
`else
  assign w_key_in = key_ch;
`endif

  assign w_frame_take = (r_state == S_IDLE) && r_frame_pend;
  assign w_key_take   = (r_state == S_KEY);
  assign w_spawn_take = (r_state == S_SPAWN);

  always_comb begin
    w_mv_slot = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (r_mv_idx == 3'(i)) w_mv_slot = r_slot[i];
    end
  end

  // 10-bit sum so a row near the bottom cannot wrap back to the top
  assign w_nx   = {1'b0, w_mv_slot.x} + {7'd0, w_mv_slot.spd};
  assign w_miss = (w_nx >= {1'b0, BOTTOM});

  // Lowest character (largest row) wins; strict compare keeps the lowest index on ties
  always_comb begin
    w_hit_found = 1'b0;
    w_hit_idx   = 3'd0;
    w_best_x    = 9'd0;
    for (int i = 0; i < SLOTS; i++) begin
      if (r_slot[i].vld && r_slot[i].ch == r_key_ch &&
          (!w_hit_found || r_slot[i].x > w_best_x)) begin
        w_hit_found = 1'b1;
        w_hit_idx   = 3'(i);
        w_best_x    = r_slot[i].x;
      end
    end
  end

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = 3'd0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!r_slot[i].vld) begin
        w_free_found = 1'b1;
        w_free_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    rd_valid = 1'b0;
    rd_ch    = 8'd0;
    rd_x     = 9'd0;
    rd_y     = 10'd0;
    for (int i = 0; i < SLOTS; i++) begin
      if (rd_idx == 3'(i)) begin
        rd_valid = r_slot[i].vld;
        rd_ch    = r_slot[i].ch;
        rd_x     = r_slot[i].x;
        rd_y     = r_slot[i].y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_mv_idx        <= 3'd0;
      r_frame_pend    <= 1'b0;
      r_key_pend      <= 1'b0;
      r_spawn_pend    <= 1'b0;
      r_key_ch        <= 8'd0;
      r_hit_cnt       <= '0;
      r_miss_cnt      <= '0;
      r_hit_pulse     <= 1'b0;
      r_miss_pulse    <= 1'b0;
      r_mistype_pulse <= 1'b0;
      for (int i = 0; i < SLOTS; i++) r_slot[i] <= '0;
    end else begin
      r_hit_pulse     <= 1'b0;
      r_miss_pulse    <= 1'b0;
      r_mistype_pulse <= 1'b0;

      // A tick arriving in the consume cycle keeps its flag set
      r_frame_pend <= frame_tick | (r_frame_pend & ~w_frame_take);
      r_key_pend   <= key_valid  | (r_key_pend   & ~w_key_take);
      r_spawn_pend <= spawn_tick | (r_spawn_pend & ~w_spawn_take);
      if (key_valid) r_key_ch <= w_key_in;

      case (r_state)
        S_IDLE: begin
          if (r_frame_pend) begin
            r_state  <= S_MOVE;
            r_mv_idx <= 3'd0;
          end else if (r_key_pend) begin
            r_state <= S_KEY;
          end else if (r_spawn_pend) begin
            r_state <= S_SPAWN;
          end
        end

        S_MOVE: begin
          for (int i = 0; i < SLOTS; i++) begin
            if (r_mv_idx == 3'(i) && r_slot[i].vld) begin
              if (w_miss) begin
                r_slot[i].vld <= 1'b0;
                r_miss_cnt    <= r_miss_cnt + 1'b1;
                r_miss_pulse  <= 1'b1;
              end else begin
                r_slot[i].x <= w_nx[8:0];
              end
            end
          end
          if (r_mv_idx == 3'(SLOTS - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_mv_idx <= r_mv_idx + 3'd1;
          end
        end

        S_KEY: begin
          if (w_hit_found) begin
            for (int i = 0; i < SLOTS; i++) begin
              if (w_hit_idx == 3'(i)) r_slot[i].vld <= 1'b0;
            end
            r_hit_cnt   <= r_hit_cnt + 1'b1;
            r_hit_pulse <= 1'b1;
          end else begin
            r_mistype_pulse <= 1'b1;
          end
          r_state <= S_IDLE;
        end

        S_SPAWN: begin
          if (w_free_found) begin
            for (int i = 0; i < SLOTS; i++) begin
              if (w_free_idx == 3'(i)) begin
                r_slot[i].vld <= 1'b1;
                r_slot[i].ch  <= gen_ch;
                r_slot[i].spd <= (gen_speed == 3'd0) ? 3'd1 : gen_speed;
                r_slot[i].x   <= gen_x;
                r_slot[i].y   <= gen_y;
              end
            end
          end
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hit_cnt       = r_hit_cnt;
  assign miss_cnt      = r_miss_cnt;
  assign hit_pulse     = r_hit_pulse;
  assign miss_pulse    = r_miss_pulse;
  assign mistype_pulse = r_mistype_pulse;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_falling_char_pool.sv
// Directed bench for falling_char_pool with hand-computed expectations.
module tb_falling_char_pool;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick, spawn_tick, key_valid;
  logic [7:0] gen_ch, key_ch;
  logic [2:0] gen_speed, rd_idx;
  logic [8:0] gen_x;
  logic [9:0] gen_y;
  logic       rd_valid;
  logic [7:0] rd_ch;
  logic [8:0] rd_x;
  logic [9:0] rd_y;
  logic [9:0] hit_cnt, miss_cnt;
  logic       hit_pulse, miss_pulse, mistype_pulse, busy;

  int n_vec = 0;
  int n_err = 0;
  int busy_cyc, n_hitp, n_missp, n_misp, n_runs, cur_run;
  int runs [8];

  falling_char_pool dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .spawn_tick(spawn_tick),
    .gen_ch(gen_ch), .gen_speed(gen_speed), .gen_x(gen_x), .gen_y(gen_y),
    .key_valid(key_valid), .key_ch(key_ch), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_ch(rd_ch), .rd_x(rd_x), .rd_y(rd_y),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .mistype_pulse(mistype_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_tick = 1'b0; spawn_tick = 1'b0; key_valid = 1'b0; key_ch = 8'd0;
    step(); step();
    rst = 1'b0;
  endtask

  // Pulse the chosen ticks for one cycle, then run a fixed window recording activity
  task automatic req(input logic f, input logic k, input logic s, input logic [7:0] kc);
    frame_tick = f; key_valid = k; spawn_tick = s; key_ch = kc;
    step();
    frame_tick = 1'b0; key_valid = 1'b0; spawn_tick = 1'b0;
    busy_cyc = 0; n_hitp = 0; n_missp = 0; n_misp = 0; n_runs = 0; cur_run = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (busy) begin
        busy_cyc++;
        cur_run++;
      end else if (cur_run != 0) begin
        if (n_runs < 8) runs[n_runs] = cur_run;
        n_runs++;
        cur_run = 0;
      end
      if (hit_pulse) n_hitp++;
      if (miss_pulse) n_missp++;
      if (mistype_pulse) n_misp++;
    end
  endtask

  task automatic spawn(input logic [7:0] c, input logic [2:0] s, input logic [8:0] x, input logic [9:0] y);
    gen_ch = c; gen_speed = s; gen_x = x; gen_y = y;
    req(1'b0, 1'b0, 1'b1, 8'd0);
  endtask

  task automatic rd(input logic [2:0] idx);
    rd_idx = idx;
    #1;
  endtask

  initial begin
    gen_ch = 8'd0; gen_speed = 3'd0; gen_x = 9'd0; gen_y = 10'd0; rd_idx = 3'd0;
    do_reset();

    // Reset state
    rd(3'd0);
    check("rst_busy", busy, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    check("rst_vld0", rd_valid, 0);
    check("rst_pulses", {hit_pulse, miss_pulse, mistype_pulse}, 0);

    // First spawn lands in slot 0
    spawn(8'd65, 3'd2, 9'd0, 10'd18);
    rd(3'd0);
    check("sp_vld", rd_valid, 1);
    check("sp_ch", rd_ch, 65);
    check("sp_x", rd_x, 0);
    check("sp_y", rd_y, 18);
    check("sp_busy", busy_cyc, 1);
    rd(3'd1);
    check("sp_vld1", rd_valid, 0);

    // Miss at the bottom: 460 + 4 = 464
    do_reset();
    spawn(8'd65, 3'd4, 9'd460, 10'd5);
    req(1'b1, 1'b0, 1'b0, 8'd0);
    rd(3'd0);
    check("miss_vld", rd_valid, 0);
    check("miss_cnt", miss_cnt, 1);
    check("miss_pulses", n_missp, 1);
    check("miss_busy", busy_cyc, 4);

    // Hit picks the largest row among matching slots
    do_reset();
    spawn(8'd66, 3'd1, 9'd100, 10'd1);
    spawn(8'd81, 3'd1, 9'd50, 10'd2);
    spawn(8'd66, 3'd1, 9'd300, 10'd3);
    req(1'b0, 1'b1, 1'b0, 8'd66);
    rd(3'd2); check("hit_vld2", rd_valid, 0);
    rd(3'd0); check("hit_vld0", rd_valid, 1);
    check("hit_x0", rd_x, 100);
    check("hit_cnt", hit_cnt, 1);
    check("hit_pulses", n_hitp, 1);
    check("hit_busy", busy_cyc, 1);

    // Mistype leaves everything alone
    req(1'b0, 1'b1, 1'b0, 8'd90);
    check("mis_pulses", n_misp, 1);
    check("mis_hitp", n_hitp, 0);
    check("mis_hit_cnt", hit_cnt, 1);
    rd(3'd0); check("mis_vld0", rd_valid, 1);
    rd(3'd1); check("mis_vld1", rd_valid, 1);
    rd(3'd2); check("mis_vld2", rd_valid, 0);

    // Lowercase key against an uppercase character
    spawn(8'd67, 3'd1, 9'd40, 10'd4);
    req(1'b0, 1'b1, 1'b0, 8'd99);
    rd(3'd2);
`ifdef KEY_CASE_FOLD_EN
    check("fold_hitp", n_hitp, 1);
    check("fold_vld2", rd_valid, 0);
    check("fold_hit_cnt", hit_cnt, 2);
`else
    check("fold_misp", n_misp, 1);
    check("fold_vld2", rd_valid, 1);
    check("fold_hit_cnt", hit_cnt, 1);
`endif

    // Full pool: spawn dropped
    do_reset();
    spawn(8'd68, 3'd4, 9'd10, 10'd1);
    spawn(8'd69, 3'd1, 9'd20, 10'd2);
    spawn(8'd70, 3'd0, 9'd30, 10'd3);
    spawn(8'd68, 3'd4, 9'd460, 10'd4);
    spawn(8'd71, 3'd3, 9'd99, 10'd99);
    rd(3'd0); check("full_ch0", rd_ch, 68);
    rd(3'd1); check("full_ch1", rd_ch, 69);
    rd(3'd2); check("full_ch2", rd_ch, 70);
    rd(3'd3); check("full_ch3", rd_ch, 68);
    check("full_x3", rd_x, 460);
    check("full_busy", busy_cyc, 1);
    rd(3'd4);
    check("oob_rd", {rd_valid, rd_ch, rd_x, rd_y}, 0);

    // Simultaneous requests: MOVE (slot3 misses), KEY 'D' hits slot0, SPAWN refills slot0
    gen_ch = 8'd72; gen_speed = 3'd2; gen_x = 9'd7; gen_y = 10'd9;
    req(1'b1, 1'b1, 1'b1, 8'd68);
    check("all_miss_cnt", miss_cnt, 1);
    check("all_hit_cnt", hit_cnt, 1);
    check("all_busy", busy_cyc, 6);
    check("all_nruns", n_runs, 3);
    check("all_run0", runs[0], 4);
    check("all_mistype", n_misp, 0);
    rd(3'd0);
    check("all_vld0", rd_valid, 1);
    check("all_ch0", rd_ch, 72);
    check("all_x0", rd_x, 7);
    check("all_y0", rd_y, 9);
    rd(3'd1); check("all_x1", rd_x, 21);
    rd(3'd2); check("all_x2", rd_x, 31);
    rd(3'd3); check("all_vld3", rd_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
